// File: rtl/zeroskip_row_mac_packer.sv
// Zero-skip row packer: compresses LANES mask-selected groups per beat to NZ elements and packs chunks into M-element words.
// Latency: a beat accepted at cycle t sits in stage 1 at t+1; a word it completes is valid at t+2.
// Backpressure: a stalled output holds its word, a completing chunk then waits in stage 1, and that drops both input rdy.
module zeroskip_row_mac_packer #(
  parameter int M          = 32,
  parameter int LANES      = 2,
  parameter int GROUP_SIZE = 32,
  parameter int DATA_W     = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         mode_i,
  input  logic [LANES*GROUP_SIZE-1:0]        znz_din,
  input  logic                               znz_din_vld_i,
  output logic                               znz_din_rdy_o,
  input  logic [LANES*GROUP_SIZE*DATA_W-1:0] act_din,
  input  logic                               act_din_vld_i,
  output logic                               act_din_rdy_o,
  input  logic                               last_i,
  output logic [M*DATA_W-1:0]                act_enc_dout,
  output logic                               act_enc_vld_o,
  input  logic                               act_enc_rdy_i,
  output logic                               act_enc_last_o,
  output logic                               ovf_o
);

  localparam int WORD_W = M * DATA_W;
  localparam int KMAX   = M / (LANES * 4);
  localparam int FILL_W = $clog2(KMAX);
  localparam int CNT_W  = $clog2(GROUP_SIZE + 1);
  // Last fill index of a word for each density (K-1)
  localparam logic [FILL_W-1:0] KL0 = FILL_W'(M / (LANES * 4) - 1);
  localparam logic [FILL_W-1:0] KL1 = FILL_W'(M / (LANES * 8) - 1);
  localparam logic [FILL_W-1:0] KL2 = FILL_W'(M / (LANES * 16) - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_norm, enc_mode;
  logic                accept, s1_free, s1_take;
  logic [CNT_W-1:0]    enc_nz, enc_cnt;
  logic [LANES-1:0]    enc_ovf;
  logic [WORD_W-1:0]   enc_chunk;
  logic                s1_vld_q, s1_last_q;
  logic [1:0]          s1_mode_q;
  logic [WORD_W-1:0]   s1_chunk_q;
  logic [WORD_W-1:0]   acc_q, acc_d, word_next;
  logic [FILL_W-1:0]   fill_q, fill_d, fill_last;
  logic                completes, out_free;
  logic                out_vld_q, out_last_q, ovf_q;
  logic [WORD_W-1:0]   out_dat_q;
  int                  shamt;

  // Reserved density code behaves as 16:32
  assign mode_norm = (mode_i == 2'd3) ? 2'd2 : mode_i;

  // Frame-mode latch state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A frame latches its mode on its first beat and releases it on its last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !last_i) state_d = ST_FILL;
      ST_FILL: if (accept && last_i)  state_d = ST_IDLE;
    endcase
  end

  // Encoding density: live input while no mode is latched, frozen otherwise
  always_comb begin
    enc_mode = mode_norm;
    if (state_q == ST_FILL) enc_mode = mode_q;
  end

  // Capture the frame mode on the beat that opens a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           mode_q <= 2'd0;
    else if (accept && state_q == ST_IDLE) mode_q <= mode_norm;
  end

  assign enc_nz = CNT_W'(4) << enc_mode;

  // Per-lane compaction: j-th set mask bit lands in lane slot j; excess set bits flag overflow
  always_comb begin
    enc_chunk = '0;
    enc_ovf   = '0;
    enc_cnt   = '0;
    for (int l = 0; l < LANES; l++) begin
      enc_cnt = '0;
      for (int i = 0; i < GROUP_SIZE; i++) begin
        if (znz_din[l*GROUP_SIZE + i]) begin
          if (enc_cnt < enc_nz) begin
            enc_chunk[(l*int'(enc_nz) + int'(enc_cnt))*DATA_W +: DATA_W] =
              act_din[(l*GROUP_SIZE + i)*DATA_W +: DATA_W];
          end else begin
            enc_ovf[l] = 1'b1;
          end
          enc_cnt = enc_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Handshake: stage 1 can take a beat when empty or draining this cycle
  assign out_free      = !out_vld_q || act_enc_rdy_i;
  assign s1_take       = s1_vld_q && (!completes || out_free);
  assign s1_free       = !s1_vld_q || s1_take;
  assign accept        = znz_din_vld_i && act_din_vld_i && s1_free;
  assign znz_din_rdy_o = s1_free;
  assign act_din_rdy_o = s1_free;

  // Stage-1 slice: compressed chunk plus its frame flag and density
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= 2'd0;
      s1_chunk_q <= '0;
    end else if (accept) begin
      s1_vld_q   <= 1'b1;
      s1_last_q  <= last_i;
      s1_mode_q  <= enc_mode;
      s1_chunk_q <= enc_chunk;
    end else if (s1_take) begin
      s1_vld_q   <= 1'b0;
    end
  end

  // Word boundary for the stage-1 chunk's density
  always_comb begin
    case (s1_mode_q)
      2'd0:    fill_last = KL0;
      2'd1:    fill_last = KL1;
      default: fill_last = KL2;
    endcase
  end

  assign shamt     = int'(fill_q) * LANES * (4 << s1_mode_q) * DATA_W;
  assign word_next = acc_q | (s1_chunk_q << shamt);
  assign completes = s1_vld_q && (s1_last_q || fill_q == fill_last);

  // Accumulator next state: absorb a chunk, or clear once its word leaves
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    if (s1_take) begin
      if (completes) begin
        acc_d  = '0;
        fill_d = '0;
      end else begin
        acc_d  = word_next;
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Accumulator and fill counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  // Output register: load a completed word (even while draining), else clear vld on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else if (s1_take && completes) begin
      out_vld_q  <= 1'b1;
      out_last_q <= s1_last_q;
      out_dat_q  <= word_next;
    end else if (act_enc_rdy_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  // Sticky overflow, raised by any accepted group with too many set bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_q <= 1'b0;
    else if (accept && |enc_ovf) ovf_q <= 1'b1;
  end

  assign act_enc_dout   = out_dat_q;
  assign act_enc_vld_o  = out_vld_q;
  assign act_enc_last_o = out_last_q;
  assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_zeroskip_row_mac_packer.sv
// Bench for zeroskip_row_mac_packer: directed vectors, a queue-based reference model and a per-cycle output checker.
module tb_zeroskip_row_mac_packer;

  localparam int M  = 32;
  localparam int LN = 2;
  localparam int GS = 32;
  localparam int DW = 8;
  localparam int WW = M * DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode_i;
  logic [LN*GS-1:0]  znz_din;
  logic              znz_din_vld_i, znz_din_rdy_o;
  logic [LN*GS*DW-1:0] act_din;
  logic              act_din_vld_i, act_din_rdy_o;
  logic              last_i;
  logic [WW-1:0]     act_enc_dout;
  logic              act_enc_vld_o, act_enc_rdy_i, act_enc_last_o, ovf_o;

  zeroskip_row_mac_packer #(.M(M), .LANES(LN), .GROUP_SIZE(GS), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
    .znz_din(znz_din), .znz_din_vld_i(znz_din_vld_i), .znz_din_rdy_o(znz_din_rdy_o),
    .act_din(act_din), .act_din_vld_i(act_din_vld_i), .act_din_rdy_o(act_din_rdy_o),
    .last_i(last_i), .act_enc_dout(act_enc_dout), .act_enc_vld_o(act_enc_vld_o),
    .act_enc_rdy_i(act_enc_rdy_i), .act_enc_last_o(act_enc_last_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int words_seen = 0;
  int words_pushed = 0;
  bit rand_rdy_en = 1'b0;

  // Reference model state
  logic [WW-1:0] exp_q[$];
  bit            exp_last_q[$];
  logic [DW-1:0] cur[$];
  bit            in_frame = 1'b0;
  int            frame_mode = 0;
  bit            exp_ovf = 1'b0;

  logic [WW-1:0] last_word;
  bit            last_word_last;
  bit            hold_vld = 1'b0;
  logic [WW-1:0] hold_dat;
  bit            hold_last;

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic logic [511:0] ramp(input int base);
    logic [511:0] a;
    for (int i = 0; i < 64; i++) a[i*8 +: 8] = 8'(base + i);
    return a;
  endfunction

  function automatic logic [63:0] rep(input logic [31:0] m);
    return {m, m};
  endfunction

  function automatic void model_reset();
    cur.delete();
    exp_q.delete();
    exp_last_q.delete();
    in_frame = 1'b0;
    exp_ovf  = 1'b0;
  endfunction

  // Words are a flat element stream: each beat appends LANES*NZ elements; a full or closed word is padded and queued
  function automatic void model_accept(input logic [1:0] m, input logic [63:0] znz,
                                       input logic [511:0] act, input bit lst);
    int nz, cnt;
    logic [WW-1:0] w;
    if (!in_frame) begin
      frame_mode = (m == 2'd3) ? 2 : int'(m);
      in_frame = 1'b1;
    end
    nz = 4 << frame_mode;
    for (int l = 0; l < LN; l++) begin
      cnt = 0;
      for (int i = 0; i < GS; i++) begin
        if (znz[l*GS + i]) begin
          if (cnt < nz) cur.push_back(act[(l*GS + i)*DW +: DW]);
          else exp_ovf = 1'b1;
          cnt++;
        end
      end
      while (cnt < nz) begin
        cur.push_back('0);
        cnt++;
      end
    end
    if (cur.size() >= M || lst) begin
      w = '0;
      for (int k = 0; k < cur.size(); k++) w[k*DW +: DW] = cur[k];
      exp_q.push_back(w);
      exp_last_q.push_back(lst);
      words_pushed++;
      cur.delete();
    end
    if (lst) in_frame = 1'b0;
  endfunction

  task automatic send_beat(input logic [1:0] m, input logic [63:0] znz,
                           input logic [511:0] act, input bit lst);
    int  waitc = 0;
    bit  done  = 1'b0;
    mode_i = m; znz_din = znz; act_din = act; last_i = lst;
    znz_din_vld_i = 1'b1; act_din_vld_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (act_din_rdy_o && znz_din_rdy_o) begin
        model_accept(m, znz, act, lst);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) begin
        waitc++;
        if (waitc > 1000) begin
          n_chk++;
          $display("FAIL send_timeout: input rdy low for %0d cycles", waitc);
          done = 1'b1;
        end
      end
    end
    znz_din_vld_i = 1'b0; act_din_vld_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || act_enc_vld_o) && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    check_bit("drain", (exp_q.size() == 0) && !act_enc_vld_o, 1'b1);
  endtask

  // Output rdy driver: held high unless the random phase is active
  initial begin
    act_enc_rdy_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      act_enc_rdy_i = rand_rdy_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Checker: every handshaked word against the model, plus stability while stalled
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check_bit("hold_vld", act_enc_vld_o, 1'b1);
          check("hold_dat", act_enc_dout, hold_dat);
          check_bit("hold_last", act_enc_last_o, hold_last);
        end
        if (act_enc_vld_o && act_enc_rdy_i) begin
          words_seen++;
          last_word = act_enc_dout;
          last_word_last = act_enc_last_o;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL word_unexpected: got %0h with none expected", act_enc_dout);
          end else begin
            check("word_dat", act_enc_dout, exp_q.pop_front());
            check_bit("word_last", act_enc_last_o, exp_last_q.pop_front());
          end
        end
        hold_vld  = act_enc_vld_o && !act_enc_rdy_i;
        hold_dat  = act_enc_dout;
        hold_last = act_enc_last_o;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ws;
    logic [1:0]   rm;
    logic [63:0]  rz;
    logic [511:0] ra;
    bit           rl;

    rst_n = 1'b0; mode_i = '0; znz_din = '0; act_din = '0;
    znz_din_vld_i = 1'b0; act_din_vld_i = 1'b0; last_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    // Reset state
    check_bit("rst_vld", act_enc_vld_o, 1'b0);
    check("rst_dout", act_enc_dout, '0);
    check_bit("rst_last", act_enc_last_o, 1'b0);
    check_bit("rst_ovf", ovf_o, 1'b0);
    check_bit("rst_act_rdy", act_din_rdy_o, 1'b1);
    check_bit("rst_znz_rdy", znz_din_rdy_o, 1'b1);
    @(posedge clk); #1;

    // 16:32, one word per beat, latency t+2
    send_beat(2'd2, rep(32'h0000FFFF), ramp(0), 1'b0);
    check_bit("lat_t1_vld", act_enc_vld_o, 1'b0);
    @(posedge clk); #1;
    check_bit("lat_t2_vld", act_enc_vld_o, 1'b1);
    check("m2_word0", act_enc_dout,
          256'h2f2e2d2c2b2a29282726252423222120_0f0e0d0c0b0a09080706050403020100);
    check_bit("m2_word0_last", act_enc_last_o, 1'b0);
    send_beat(2'd2, rep(32'h0000FFFF), ramp(64), 1'b1);
    wait_drain();
    check("m2_word1", last_word,
          256'h6f6e6d6c6b6a69686766656463626160_4f4e4d4c4b4a49484746454443424140);
    check_bit("m2_word1_last", last_word_last, 1'b1);

    // 4:32, four beats packed into one word in arrival order
    ws = words_seen;
    for (int b = 0; b < 4; b++) send_beat(2'd0, rep(32'h00002222), ramp(b*64), b == 3);
    wait_drain();
    check_int("m0_word_count", words_seen - ws, 1);
    check("m0_word", last_word,
          256'hede9e5e1cdc9c5c1_ada9a5a18d898581_6d6965614d494541_2d2925210d090501);
    check_bit("m0_last", last_word_last, 1'b1);

    // 8:32, single last beat flushes a half-empty word
    send_beat(2'd1, rep(32'h00005555), ramp(100), 1'b1);
    wait_drain();
    check("m1_flush", last_word,
          256'h00000000000000000000000000000000_92908e8c8a888684_72706e6c6a686664);
    check_bit("m1_flush_last", last_word_last, 1'b1);
    check_bit("ovf_clean", ovf_o, 1'b0);

    // Overflow: dense mask in 4:32 keeps the first four per lane
    send_beat(2'd0, rep(32'hFFFFFFFF), ramp(0), 1'b1);
    wait_drain();
    check("ovf_word", last_word, {192'h0, 64'h2322212003020100});
    check_bit("ovf_set", ovf_o, 1'b1);
    send_beat(2'd2, rep(32'h0000FFFF), ramp(5), 1'b0);
    send_beat(2'd2, rep(32'h0000FFFF), ramp(9), 1'b1);
    wait_drain();
    check_bit("ovf_sticky", ovf_o, 1'b1);

    // Random masks, modes and frame ends under 30% output rdy
    rand_rdy_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rm = 2'($urandom_range(0, 3));
      for (int l = 0; l < LN; l++) begin
        case ($urandom_range(0, 2))
          0:       rz[l*32 +: 32] = $urandom & $urandom & $urandom;
          1:       rz[l*32 +: 32] = $urandom & $urandom;
          default: rz[l*32 +: 32] = $urandom;
        endcase
      end
      for (int k = 0; k < 16; k++) ra[k*32 +: 32] = $urandom;
      rl = ($urandom_range(0, 7) == 0) || (n == 999);
      send_beat(rm, rz, ra, rl);
    end
    rand_rdy_en = 1'b0;
    wait_drain();
    check_int("rand_word_count", words_seen, words_pushed);
    check_bit("rand_ovf", ovf_o, exp_ovf);

    // Reset mid-frame discards the partial word and the latched mode
    ws = words_seen;
    send_beat(2'd0, rep(32'h00002222), ramp(0), 1'b0);
    send_beat(2'd0, rep(32'h00002222), ramp(64), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_bit("prerst_no_word", act_enc_vld_o, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_bit("rst_mid_ovf", ovf_o, 1'b0);
    check_bit("rst_mid_vld", act_enc_vld_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(2'd2, rep(32'h0000FFFF), ramp(0), 1'b0);
    send_beat(2'd2, rep(32'h0000FFFF), ramp(64), 1'b1);
    wait_drain();
    check_int("rst_word_count", words_seen - ws, 2);
    check("rst_new_frame", last_word,
          256'h6f6e6d6c6b6a69686766656463626160_4f4e4d4c4b4a49484746454443424140);
    check_bit("rst_new_last", last_word_last, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
